// File: rtl/rf_bypass_sb.sv
// rf_bypass_sb: dual-write-port register file with write-to-read bypass,
// synchronous clear and a per-register pending scoreboard with a registered
// count of outstanding destinations.
module rf_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rv1,
    output logic [DATA_W-1:0] rv2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] rd0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rd1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam bit                ZR       = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    // Whole-file clear on reset rules out a RAM macro; the array is flops.
    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;

    // A write that actually lands in the array (hardwired zero register drops it).
    logic wr0_ok;
    logic wr1_ok;
    assign wr0_ok = we0 && !(ZR && (rd0 == ZERO_IDX));
    assign wr1_ok = we1 && !(ZR && (rd1 == ZERO_IDX));

    // Array update; port 1 is written last so it wins an index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs_reg[rd0] <= wd0;
            end
            if (wr1_ok) begin
                regs_reg[rd1] <= wd1;
            end
        end
    end

    // Next pending bit per register: a new reservation beats a same-cycle
    // writeback, since it names a newer producer for that destination.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic set_hit;
            logic clr_hit;
            assign set_hit = rsv_en && (rsv_rd == IDX);
            assign clr_hit = (we0 && (rd0 == IDX)) || (we1 && (rd1 == IDX));
            if (ZR && (gi == 0)) begin : g_zero
                assign pend_next[gi] = 1'b0;
            end else begin : g_norm
                assign pend_next[gi] = set_hit | (pend_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    // Count of pending bits as they will stand after this edge.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (ADDR_W + 1)'(pend_next[i]);
        end
    end

    // Scoreboard and its count advance together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign pend_cnt = cnt_reg;

    // Two identical read ports: zero register, then port 1, then port 0 bypass,
    // then the array. A bypassed operand is available, hence never busy.
    logic [1:0][ADDR_W-1:0] rs_sel;
    logic [1:0][DATA_W-1:0] rv_sel;
    logic [1:0]             busy_sel;

    assign rs_sel[0] = rs1;
    assign rs_sel[1] = rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic is_zero;
            logic hit0;
            logic hit1;
            assign is_zero = ZR && (rs_sel[gi] == ZERO_IDX);
            assign hit0    = we0 && (rd0 == rs_sel[gi]);
            assign hit1    = we1 && (rd1 == rs_sel[gi]);
            assign rv_sel[gi] = is_zero ? '0 :
                                hit1    ? wd1 :
                                hit0    ? wd0 :
                                          regs_reg[rs_sel[gi]];
            assign busy_sel[gi] = ~is_zero & pend_reg[rs_sel[gi]] & ~hit0 & ~hit1;
        end
    endgenerate

    assign rv1   = rv_sel[0];
    assign rv2   = rv_sel[1];
    assign busy1 = busy_sel[0];
    assign busy2 = busy_sel[1];

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Scoreboard bench for rf_bypass_sb: the driver applies one input vector per
// cycle and queues the expected outputs from a register-level model; a monitor
// on the falling edge pops and compares.
module tb_rf_bypass_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic [31:0] rv1, rv2;
    logic        busy1, busy2;
    logic        we0, we1;
    logic [4:0]  rd0, rd1;
    logic [31:0] wd0, wd1;
    logic        rsv_en;
    logic [4:0]  rsv_rd;
    logic [5:0]  pend_cnt;

    rf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
        .busy1(busy1), .busy2(busy2),
        .we0(we0), .rd0(rd0), .wd0(wd0),
        .we1(we1), .rd1(rd1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic        busy1;
        logic        busy2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;

    // Reference model: architectural contents and the set of pending registers.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    function automatic int model_count();
        int n = 0;
        foreach (m_pend[i]) if (m_pend[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (we1 && rd1 == idx) return wd1;
        if (we0 && rd0 == idx) return wd0;
        return m_regs[idx];
    endfunction

    function automatic logic model_busy(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if ((we1 && rd1 == idx) || (we0 && rd0 == idx)) return 1'b0;
        return m_pend[idx];
    endfunction

    task automatic model_clear();
        foreach (m_regs[i]) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    // One cycle: drive, queue expectation, take the edge, advance the model.
    task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e0, input logic [4:0] d0, input logic [31:0] v0,
                       input logic e1, input logic [4:0] d1, input logic [31:0] v1,
                       input logic re, input logic [4:0] rr);
        exp_t e;
        rst = r; rs1 = a1; rs2 = a2;
        we0 = e0; rd0 = d0; wd0 = v0;
        we1 = e1; rd1 = d1; wd1 = v1;
        rsv_en = re; rsv_rd = rr;
        e.id    = txn_id;
        e.rs1   = a1;
        e.rs2   = a2;
        e.rv1   = model_read(a1);
        e.rv2   = model_read(a2);
        e.busy1 = model_busy(a1);
        e.busy2 = model_busy(a2);
        e.cnt   = 6'(model_count());
        sb.push_back(e);
        txn_id++;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (e0 && d0 != 5'd0) m_regs[d0] = v0;
            if (e1 && d1 != 5'd0) m_regs[d1] = v1;
            if (e0) m_pend[d0] = 1'b0;
            if (e1) m_pend[d1] = 1'b0;
            if (re && rr != 5'd0) m_pend[rr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_rd(input logic [4:0] a1, input logic [4:0] a2);
        cyc(0, a1, a2, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rsv(input logic [4:0] idx);
        cyc(0, idx, 0, 0, 0, 0, 0, 0, 0, 1, idx);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %0d rs1=%0d rs2=%0d rv1=%h rv2=%h busy=%b%b cnt=%0d",
                     e.id, e.rs1, e.rs2, rv1, rv2, busy1, busy2, pend_cnt);
            checks += 5;
            if (rv1 !== e.rv1) begin
                failures++;
                $display("FAIL rv1 txn %0d: got %h expected %h", e.id, rv1, e.rv1);
            end
            if (rv2 !== e.rv2) begin
                failures++;
                $display("FAIL rv2 txn %0d: got %h expected %h", e.id, rv2, e.rv2);
            end
            if (busy1 !== e.busy1) begin
                failures++;
                $display("FAIL busy1 txn %0d: got %b expected %b", e.id, busy1, e.busy1);
            end
            if (busy2 !== e.busy2) begin
                failures++;
                $display("FAIL busy2 txn %0d: got %b expected %b", e.id, busy2, e.busy2);
            end
            if (pend_cnt !== e.cnt) begin
                failures++;
                $display("FAIL pend_cnt txn %0d: got %0d expected %0d", e.id, pend_cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [4:0] a, b, c, d, f;
        rst = 1'b1; rs1 = 0; rs2 = 0;
        we0 = 0; rd0 = 0; wd0 = 0;
        we1 = 0; rd1 = 0; wd1 = 0;
        rsv_en = 0; rsv_rd = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset wipes data; same-cycle write and reservation are lost.
        cyc(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle_rd(5, 0);
        cyc(1, 5, 0, 0, 0, 0, 1, 5, 32'h1, 1, 5);
        idle_rd(5, 5);

        // Zero register ignores writes and reservations.
        cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        idle_rd(0, 0);

        // Dual-write collision: port 1 wins both in bypass and in the array.
        cyc(0, 7, 0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
        idle_rd(7, 7);

        // Scoreboard flow: reserve, observe busy, clear via writeback.
        rsv(3);
        idle_rd(3, 0);
        cyc(0, 3, 3, 0, 0, 0, 1, 3, 32'hABCD, 0, 0);
        idle_rd(3, 0);

        // Reserve/write race on an already pending register.
        rsv(9);
        cyc(0, 9, 0, 1, 9, 32'h55, 0, 0, 0, 1, 9);
        idle_rd(9, 9);

        // Count saturation with a WAW re-reservation along the way.
        for (int i = 1; i < 32; i++) begin
            rsv(5'(i));
            if (i == 10) rsv(4);
        end
        idle_rd(4, 31);
        rsv(4);
        idle_rd(4, 1);

        // Clear everything through writebacks on both ports.
        for (int i = 0; i < 32; i += 2) begin
            cyc(0, 5'(i), 5'(i + 1), 1, 5'(i), $urandom, 1, 5'(i + 1), $urandom, 0, 0);
        end
        idle_rd(2, 3);

        // Randomized traffic, indices biased toward a small set to force hits.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            b = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            c = 5'($urandom_range(0, 5));
            d = ($urandom_range(0, 2) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            f = 5'($urandom_range(0, 7));
            cyc(($urandom_range(0, 59) == 0), a, b,
                1'($urandom), c, $urandom,
                1'($urandom), d, $urandom,
                1'($urandom), f);
        end
        idle_rd(1, 2);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
